uart_sync_fifo: RTL and testbench
=================================

// Module: uart_sync_fifo
// PURPOSE
//  Parametrised synchronous FIFO for the UART TX/RX data paths. Replaces the fixed 8x16 TX FIFO.
//  Adds generic width/depth, almost-full/almost-empty levels, sticky overflow/underflow flags and a flush.
//  Show-ahead (first-word fall-through) read. Single clock domain, between CPU register I/F and UART shifter.
// PARAMETERS
//  DATA_W   8   data word width, >=1
//  DEPTH    16  number of entries; power of 2, >=2
//  AFULL    12  almost_full asserted when count >= AFULL (1..DEPTH)
//  AEMPTY   2   almost_empty asserted when count <= AEMPTY (0..DEPTH-1)
// PORTS
//  clk          in   1              clock, all logic on posedge
//  rstn         in   1              synchronous reset, active-low
//  flush        in   1              synchronous clear of contents (flags untouched)
//  push         in   1              write request, data_in captured on same edge
//  data_in      in   DATA_W         write data
//  pop          in   1              read request; consumes head word
//  data_out     out  DATA_W         head word (show-ahead), 0 when empty
//  empty        out  1              count == 0
//  full         out  1              count == DEPTH
//  almost_empty out  1              count <= AEMPTY
//  almost_full  out  1              count >= AFULL
//  count        out  $clog2(DEPTH)+1 current occupancy 0..DEPTH
//  clr_err      in   1              clears overflow/underflow
//  overflow     out  1              sticky: push refused because full
//  underflow    out  1              sticky: pop refused because empty
// BEHAVIOUR
//  - Reset (clk with rstn=0): pointers=0, count=0, overflow=underflow=0. Hence empty=1, full=0,
//    almost_empty=1, almost_full=0, data_out=0. Storage array is not reset.
//  - Pointers: wr_ptr/rd_ptr are $clog2(DEPTH) bits, wrap naturally DEPTH-1 -> 0. count is separate register.
//  - Accepted ops: wr_ok = push & (~full | pop); rd_ok = pop & ~empty.
//    push@full with pop: both accepted, count unchanged. push@empty with pop: write only, rd refused, count+1.
//  - count_next = count + wr_ok - rd_ok; never exceeds DEPTH, never below 0.
//  - Write latency: word written at edge N is visible on data_out after edge N (same-cycle pop of it not possible).
//  - data_out combinational from mem[rd_ptr], gated to 0 while empty.
//  - Status outputs are combinational decodes of registered count; no extra latency.
//  - overflow set on push & full & ~pop; underflow set on pop & empty. Sticky until clr_err or reset.
//    Set has priority over clr_err in the same cycle.
//  - flush: pointers and count -> 0 on next edge; overrides push/pop in that cycle (no write occurs,
//    no error flag set). Flags keep their value.
//  - rstn has priority over flush, clr_err, push, pop. Reset mid-traffic discards contents in one cycle.
//  - No X on outputs after first reset edge, regardless of push/pop values.
// STRUCTURE
//  - Shared package uart_pkg: UART_DATA_W=8, UART_FIFO_DEPTH=16 defaults; typedef fifo_status_t
//    {empty, full, almost_empty, almost_full, overflow, underflow} for CSR mapping.
//  - Sub-module uart_fifo_ram: DEPTH x DATA_W array, one write port (we, waddr, wdata), async read port.
//  - Top keeps pointers, counter, flag logic; target 150-250 lines total.
// TESTING (defaults DATA_W=8, DEPTH=16, AFULL=12, AEMPTY=2)
//  1 Reset then idle -> empty=1, almost_empty=1, count=0, data_out=0x00, overflow=underflow=0.
//  2 Push 0x00..0x0F, then pop 16 -> data_out reads 0x00..0x0F in order; full=1 after 16th push,
//    almost_full=1 from count 12, empty=1 after last pop; rd/wr pointers wrapped once.
//  3 Fill to 16, push 0xAA alone -> count stays 16, overflow=1; push 0xBB with pop -> count 16,
//    0xBB becomes last word; clr_err -> overflow=0.
//  4 Empty FIFO, pop alone -> underflow=1, count 0; push 0x55 with pop -> count=1, data_out=0x55.
//  5 Fill to 9, assert flush with push 0x77 -> count=0, empty=1, 0x77 not stored, flags unchanged.
//  6 Fill to 5, assert rstn=0 one cycle with push=1,pop=1 -> count=0, all outputs at reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default data-path sizes and the FIFO status word
// that the CSR block maps into its status register.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the UART FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module uart_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Parametrised show-ahead synchronous FIFO for the UART TX/RX data paths,
// with almost-full/almost-empty levels, sticky error flags and flush.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int AFULL  = 12,
    parameter int AEMPTY = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     pop,
    output logic [DATA_W-1:0]        data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clr_err,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt_q;
    logic              ovf_q;
    logic              udf_q;
    logic [DATA_W-1:0] rdata;
    logic              wr_ok;
    logic              rd_ok;
    logic              ovf_set;
    logic              udf_set;
    fifo_status_t      status;

    // Handshake: push/pop are single-cycle requests sampled on the rising edge.
    // A push is accepted unless the FIFO is full with no simultaneous pop; a pop
    // is accepted only when the FIFO holds data. Refused requests set the sticky
    // error flags. Flush suppresses both requests and any flag setting.
    assign wr_ok   = ~flush & push & (~status.full | pop);
    assign rd_ok   = ~flush & pop & ~status.empty;
    assign ovf_set = ~flush & push & status.full & ~pop;
    assign udf_set = ~flush & pop & status.empty;

    uart_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt_q <= cnt_q + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    // Set wins over clear so an error in the clearing cycle is never lost.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~clr_err);
            udf_q <= udf_set | (udf_q & ~clr_err);
        end
    end

    assign status.empty        = (cnt_q == '0);
    assign status.full         = (cnt_q == CW'(DEPTH));
    assign status.almost_empty = (cnt_q <= CW'(AEMPTY));
    assign status.almost_full  = (cnt_q >= CW'(AFULL));
    assign status.overflow     = ovf_q;
    assign status.underflow    = udf_q;

    assign empty        = status.empty;
    assign full         = status.full;
    assign almost_empty = status.almost_empty;
    assign almost_full  = status.almost_full;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;
    assign count        = cnt_q;
    assign data_out     = status.empty ? '0 : rdata;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Self-checking bench for uart_sync_fifo at default parameters: directed
// vector table, hand-written corner sequences and randomized traffic.
module tb_uart_sync_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 12;
    localparam int AEMPTY = 2;

    logic              clk;
    logic              rstn;
    logic              flush;
    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    logic [DATA_W-1:0] data_out;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [4:0]        count;
    logic              clr_err;
    logic              overflow;
    logic              underflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: queue of stored words plus the two sticky flags.
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_ovf;
    logic              exp_udf;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AFULL  (AFULL),
        .AEMPTY (AEMPTY)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Clock and reset-state block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Model update from the rules: reset, then flush, then queue semantics.
    task automatic model_step(input logic p, po, fl, ce, rs, input logic [DATA_W-1:0] d);
        int  n;
        bit  do_rd;
        bit  do_wr;
        bit  oset;
        bit  uset;
        n = exp_q.size();
        if (!rs) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            oset = !fl && p && (n == DEPTH) && !po;
            uset = !fl && po && (n == 0);
            if (fl) begin
                exp_q.delete();
            end else begin
                do_rd = po && (n > 0);
                do_wr = p && ((n < DEPTH) || po);
                if (do_rd) void'(exp_q.pop_front());
                if (do_wr) exp_q.push_back(d);
            end
            exp_ovf = oset ? 1'b1 : (ce ? 1'b0 : exp_ovf);
            exp_udf = uset ? 1'b1 : (ce ? 1'b0 : exp_udf);
        end
    endtask

    task automatic check_all();
        int n;
        n = exp_q.size();
        check("count", int'(count), n);
        check("empty", int'(empty), int'(n == 0));
        check("full", int'(full), int'(n == DEPTH));
        check("almost_empty", int'(almost_empty), int'(n <= AEMPTY));
        check("almost_full", int'(almost_full), int'(n >= AFULL));
        check("overflow", int'(overflow), int'(exp_ovf));
        check("underflow", int'(underflow), int'(exp_udf));
        check("data_out", int'(data_out), (n > 0) ? int'(exp_q[0]) : 0);
    endtask

    // Driver: apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic do_cycle(input logic p, po, fl, ce, rs, input logic [DATA_W-1:0] d);
        push    = p;
        pop     = po;
        flush   = fl;
        clr_err = ce;
        rstn    = rs;
        data_in = d;
        @(posedge clk);
        model_step(p, po, fl, ce, rs, d);
        #1;
        check_all();
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic pop_word();
        do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    endtask

    typedef struct {
        logic              push;
        logic              pop;
        logic              flush;
        logic              clr_err;
        logic [DATA_W-1:0] data;
        int                exp_count;
        int                exp_dout;
        int                exp_ovf;
        int                exp_udf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Directed table starting from an empty, error-free FIFO.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 8'h00, 0, 1}; // pop on empty
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 1, 8'h55, 0, 1}; // push+pop on empty
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h55, 0, 0}; // clr_err
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h66, 2, 8'h55, 0, 0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h66, 0, 0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h88, 1, 8'h88, 0, 0}; // simultaneous
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h77, 0, 8'h00, 0, 0}; // flush beats push
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 0, 8'h00, 0, 1}; // set beats clear

        exp_q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = '0; rstn = 1'b0;

        // 1: reset then idle
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle();
        check("rst_empty", int'(empty), 1);
        check("rst_almost_empty", int'(almost_empty), 1);
        check("rst_data_out", int'(data_out), 0);

        // 2: fill 0x00..0x0F then drain in order (pointers wrap once)
        for (int i = 0; i < DEPTH; i++) begin
            push_word(DATA_W'(i));
            check("fill_almost_full", int'(almost_full), int'(i + 1 >= AFULL));
        end
        check("fill_full", int'(full), 1);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", int'(data_out), i);
            pop_word();
        end
        check("drain_empty", int'(empty), 1);

        // 3: overflow, push+pop at full, clr_err
        for (int i = 0; i < DEPTH; i++) push_word(DATA_W'(8'h20 + i));
        push_word(8'hAA);
        check("ovf_count", int'(count), DEPTH);
        check("ovf_flag", int'(overflow), 1);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hBB);
        check("full_pushpop_count", int'(count), DEPTH);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        check("ovf_cleared", int'(overflow), 0);
        for (int i = 0; i < DEPTH - 1; i++) pop_word();
        check("last_word_bb", int'(data_out), 8'hBB);
        pop_word();

        // 4: directed vector table
        foreach (vecs[k]) begin
            do_cycle(vecs[k].push, vecs[k].pop, vecs[k].flush, vecs[k].clr_err, 1'b1, vecs[k].data);
            check($sformatf("vec%0d_count", k), int'(count), vecs[k].exp_count);
            check($sformatf("vec%0d_dout", k), int'(data_out), vecs[k].exp_dout);
            check($sformatf("vec%0d_ovf", k), int'(overflow), vecs[k].exp_ovf);
            check($sformatf("vec%0d_udf", k), int'(underflow), vecs[k].exp_udf);
        end

        // 5: flush with push leaves flags alone (underflow still set here)
        for (int i = 0; i < 9; i++) push_word(DATA_W'(8'h40 + i));
        do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77);
        check("flush_count", int'(count), 0);
        check("flush_empty", int'(empty), 1);
        check("flush_udf_kept", int'(underflow), 1);
        push_word(8'h31);
        check("after_flush_head", int'(data_out), 8'h31);

        // 6: reset mid-traffic with push and pop asserted
        for (int i = 0; i < 4; i++) push_word(DATA_W'(8'h60 + i));
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
        check("midrst_count", int'(count), 0);
        check("midrst_empty", int'(empty), 1);
        check("midrst_full", int'(full), 0);
        check("midrst_udf", int'(underflow), 0);
        check("midrst_dout", int'(data_out), 0);
        idle();

        // Randomized traffic against the model, alternating fill/drain bias.
        for (int i = 0; i < 3000; i++) begin
            int pw;
            pw = ((i / 250) % 2 == 0) ? 70 : 30;
            do_cycle(($urandom_range(0, 99) < pw),
                     ($urandom_range(0, 99) < (100 - pw)),
                     ($urandom_range(0, 63) == 0),
                     ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 199) != 0),
                     DATA_W'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
